// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload at period boundaries.
// Optional feature macro CLKDIV_ODD50_EN: a negedge retiming flop gives 50% duty for odd divisors.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic [CNT_W-1:0] div_cur,
  output logic             tick,
  output logic             clkout
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TWO     = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pend_val;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W:0]   half;
  logic             wrap;
  logic             q;

  // Period bookkeeping: high-phase length, wrap detect, next count, clamped load value.
  always_comb begin
    half     = ({1'b0, div_cur} + {ZERO, 1'b1}) >> 1;
    wrap     = (cnt >= (div_cur - ONE));
    cnt_nxt  = ZERO;
    load_val = div_in;
    if (wrap) begin
      cnt_nxt = ZERO;
    end else begin
      cnt_nxt = cnt + ONE;
    end
    if (div_in < TWO) begin
      load_val = TWO;
    end else begin
      load_val = div_in;
    end
  end

  // A load on a wrap edge takes priority, so it is applied one period later.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt         <= DIV_RST - ONE;
      div_cur     <= DIV_RST;
      pend_val    <= ZERO;
      div_pending <= 1'b0;
      q           <= 1'b0;
      tick        <= 1'b0;
    end else begin
      if (div_load) begin
        pend_val    <= load_val;
        div_pending <= 1'b1;
      end else if (en && wrap && div_pending) begin
        div_cur     <= pend_val;
        div_pending <= 1'b0;
      end
      if (en) begin
        cnt  <= cnt_nxt;
        q    <= ({1'b0, cnt_nxt} < half);
        tick <= (cnt_nxt == ZERO);
      end else begin
        tick <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic q_n;

  // Half-cycle delayed copy of q; ANDing trims the odd divisor's extra high half-cycle.
  always_ff @(negedge clkin) begin
    if (rst) begin
      q_n <= 1'b0;
    end else begin
      q_n <= q;
    end
  end

  assign clkout = div_cur[0] ? (q & q_n) : q;
`else
  assign clkout = q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; expected waveforms are hand-derived bit patterns.
`timescale 1ns/1ps
module tb_clk_div_prog;

  logic        clkin;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic        div_pending;
  logic [15:0] div_cur;
  logic        tick;
  logic        clkout;

  int tests_run    = 0;
  int tests_failed = 0;

  clk_div_prog #(.CNT_W(16), .DEFAULT_DIV(2)) dut (
    .clkin      (clkin),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_pending(div_pending),
    .div_cur    (div_cur),
    .tick       (tick),
    .clkout     (clkout)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; load strobe is one-shot.
  task automatic step();
    @(posedge clkin);
    #1;
    div_load = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    div_in   = v;
    div_load = 1'b1;
  endtask

  // Step n edges, checking clkout/tick against patterns read left to right.
  task automatic run_seq(input string tag, input int n, input logic [31:0] ec, input logic [31:0] et);
    for (int i = 0; i < n; i++) begin
      step();
      check_value($sformatf("%s_clk%0d", tag, i), {31'd0, clkout}, {31'd0, ec[n-1-i]});
      check_value($sformatf("%s_tick%0d", tag, i), {31'd0, tick}, {31'd0, et[n-1-i]});
    end
  endtask

`ifdef CLKDIV_ODD50_EN
  realtime t_rise;
  realtime t_fall;
  logic    prev;
`endif

  initial begin
    rst = 1'b1; en = 1'b0; div_in = 16'd0; div_load = 1'b0;
    step();
    check_value("rst_clk", {31'd0, clkout}, 32'd0);
    check_value("rst_tick", {31'd0, tick}, 32'd0);
    check_value("rst_div", {16'd0, div_cur}, 32'd2);
    check_value("rst_pend", {31'd0, div_pending}, 32'd0);

    // D=2 default: toggle every edge starting high
    rst = 1'b0; en = 1'b1;
    run_seq("d2", 6, 32'b101010, 32'b101010);

    // Load 5 on a wrap edge: applied at the following wrap
    load(16'd5);
    step();
    check_value("l5_clk", {31'd0, clkout}, 32'd1);
    check_value("l5_pend", {31'd0, div_pending}, 32'd1);
    check_value("l5_div_old", {16'd0, div_cur}, 32'd2);
    step();
    check_value("l5_pend2", {31'd0, div_pending}, 32'd1);
    step();
    check_value("l5_apply_pend", {31'd0, div_pending}, 32'd0);
    check_value("l5_apply_div", {16'd0, div_cur}, 32'd5);
    check_value("l5_apply_tick", {31'd0, tick}, 32'd1);
    run_seq("d5", 5, 32'b11001, 32'b00001);

    // Go to D=4, then load 3 at cnt=1: period of 4 completes first
    load(16'd4);
    step();
    run_seq("to4", 4, 32'b1001, 32'b0001);
    check_value("d4_div", {16'd0, div_cur}, 32'd4);
    step();
    check_value("d4_c1_clk", {31'd0, clkout}, 32'd1);
    load(16'd3);
    run_seq("to3", 7, 32'b0011011, 32'b0010010);
    check_value("d3_div", {16'd0, div_cur}, 32'd3);

    // Load at a wrap edge with D=3: applied one period later
    step();
    check_value("d3_c2_clk", {31'd0, clkout}, 32'd0);
    load(16'd4);
    step();
    check_value("wl_tick", {31'd0, tick}, 32'd1);
    check_value("wl_pend", {31'd0, div_pending}, 32'd1);
    check_value("wl_div_old", {16'd0, div_cur}, 32'd3);
    run_seq("wl", 3, 32'b101, 32'b001);
    check_value("wl_div_new", {16'd0, div_cur}, 32'd4);
    check_value("wl_pend_clr", {31'd0, div_pending}, 32'd0);

    // Freeze 7 cycles in the high phase, then resume
    en = 1'b0;
    run_seq("frz", 7, 32'b1111111, 32'b0000000);
    en = 1'b1;
    run_seq("res", 4, 32'b1001, 32'b0001);

    // Clamp: 0 then 1 -> 2
    load(16'd0);
    step();
    load(16'd1);
    step();
    check_value("clamp_pend", {31'd0, div_pending}, 32'd1);
    check_value("clamp_div_old", {16'd0, div_cur}, 32'd4);
    step();
    step();
    check_value("clamp_div", {16'd0, div_cur}, 32'd2);

    // Back-to-back 6 then 9: last wins
    load(16'd6);
    step();
    load(16'd9);
    step();
    check_value("b2b_div_old", {16'd0, div_cur}, 32'd2);
    step();
    step();
    check_value("b2b_div", {16'd0, div_cur}, 32'd9);
    check_value("b2b_pend", {31'd0, div_pending}, 32'd0);

    // Reset in low phase with pending load (and a load on the reset edge)
    for (int i = 0; i < 5; i++) step();
    check_value("d9_low_clk", {31'd0, clkout}, 32'd0);
    load(16'd7);
    step();
    check_value("pre_rst_pend", {31'd0, div_pending}, 32'd1);
    rst = 1'b1;
    load(16'd7);
    step();
    check_value("rst2_clk", {31'd0, clkout}, 32'd0);
    check_value("rst2_tick", {31'd0, tick}, 32'd0);
    check_value("rst2_pend", {31'd0, div_pending}, 32'd0);
    check_value("rst2_div", {16'd0, div_cur}, 32'd2);
    rst = 1'b0;
    run_seq("post_rst", 4, 32'b1010, 32'b1010);
    check_value("post_rst_div", {16'd0, div_cur}, 32'd2);

`ifdef CLKDIV_ODD50_EN
    // D=3 with odd-50 retiming: high exactly 15 ns (1.5 periods)
    load(16'd3);
    for (int i = 0; i < 4; i++) step();
    t_rise = -1.0; t_fall = -1.0;
    #0.5;
    prev = clkout;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (!prev && clkout && t_rise < 0.0) t_rise = $realtime;
      if (prev && !clkout && t_rise >= 0.0 && t_fall < 0.0) t_fall = $realtime;
      prev = clkout;
    end
    check_value("odd50_seen", {31'd0, (t_fall >= 0.0)}, 32'd1);
    check_value("odd50_high_ns", 32'($rtoi(t_fall - t_rise)), 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
